// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch-direction predictor.
// Counter encodings, controller states and the table init value.
package branch_predictor_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   localparam logic [1:0] PHT_INIT = WNT;

endpackage

// File: rtl/branch_predictor_sat.sv
// 2-bit saturating counter step: taken counts up, not-taken down.
// Purely combinational; used on the update read port of the table.
module sat_counter_update
   import branch_predictor_pkg::*;
(
   input  logic [1:0] cur_i,
   input  logic       taken_i,
   output logic [1:0] next_o
);

   always_comb begin
      next_o = cur_i;
      if (taken_i) begin
         if (cur_i != ST) begin
            next_o = cur_i + 2'd1;
         end
      end else if (cur_i != SNT) begin
         next_o = cur_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit branch-direction predictor with post-reset table init.
// Define BRANCH_PRED_STATS_EN to build the branch/mispredict counters.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int INDEX_BITS = 6
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] FetchPC,
   output logic        PredictTaken,
   output logic        Ready,
   input  logic        ResolveValid,
   input  logic [31:0] ResolvePC,
   input  logic        BranchTaken,
   input  logic        PredictedTaken,
   output logic        Mispredict,
   output logic [31:0] BranchCount,
   output logic [31:0] MispredictCount
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   state_e                state_q, state_d;
   logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
   logic [1:0]            pht_q [ENTRIES];
   logic [1:0]            pht_d [ENTRIES];

   logic [INDEX_BITS-1:0] fetch_idx;
   logic [INDEX_BITS-1:0] resolve_idx;
   logic [1:0]            resolve_ctr;
   logic [1:0]            resolve_next;
   logic                  is_init;
   logic                  unused_pc_bits;

   assign fetch_idx   = FetchPC[INDEX_BITS+1:2];
   assign resolve_idx = ResolvePC[INDEX_BITS+1:2];
   assign resolve_ctr = pht_q[resolve_idx];

   // Upper PC bits alias freely; the low two are always zero.
   assign unused_pc_bits = ^{FetchPC[31:INDEX_BITS+2], FetchPC[1:0],
                             ResolvePC[31:INDEX_BITS+2], ResolvePC[1:0]};

   sat_counter_update u_sat (
      .cur_i   (resolve_ctr),
      .taken_i (BranchTaken),
      .next_o  (resolve_next)
   );

   assign is_init      = (state_q == INIT);
   assign Ready        = ~is_init;
   assign PredictTaken = ~is_init & pht_q[fetch_idx][1];
   assign Mispredict   = ResolveValid & (BranchTaken != PredictedTaken) & ~rst;

   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      pht_d      = pht_q;
      if (!rst) begin
         unique case (state_q)
            INIT: begin
               pht_d[init_idx_q] = PHT_INIT;
               init_idx_d        = init_idx_q + INDEX_BITS'(1);
               if (init_idx_q == '1) begin
                  state_d = READY;
               end
            end
            READY: begin
               if (ResolveValid) begin
                  pht_d[resolve_idx] = resolve_next;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= INIT;
         init_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
      end
   end

   // Table contents need no reset: INIT rewrites every entry.
   always_ff @(posedge clk) begin
      pht_q <= pht_d;
   end

`ifdef BRANCH_PRED_STATS_EN
   logic [31:0] branch_cnt_q, branch_cnt_d;
   logic [31:0] mispred_cnt_q, mispred_cnt_d;

   always_comb begin
      branch_cnt_d  = branch_cnt_q + {31'd0, ResolveValid};
      mispred_cnt_d = mispred_cnt_q + {31'd0, Mispredict};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign BranchCount     = branch_cnt_q;
   assign MispredictCount = mispred_cnt_q;
`else
   assign BranchCount     = '0;
   assign MispredictCount = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: driver queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_branch_predictor;

   localparam int K_READY = 0;
   localparam int K_PRED  = 1;
   localparam int K_MISP  = 2;
   localparam int K_BCNT  = 3;
   localparam int K_MCNT  = 4;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fpc;
   logic        pred;
   logic        ready;
   logic        rv;
   logic [31:0] rpc;
   logic        bt;
   logic        pt;
   logic        misp;
   logic [31:0] bcnt;
   logic [31:0] mcnt;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] bc_m = 0;
   logic [31:0] mc_m = 0;

   always #5 clk = ~clk;

   branch_predictor #(.INDEX_BITS(6)) dut (
      .clk             (clk),
      .rst             (rst),
      .FetchPC         (fpc),
      .PredictTaken    (pred),
      .Ready           (ready),
      .ResolveValid    (rv),
      .ResolvePC       (rpc),
      .BranchTaken     (bt),
      .PredictedTaken  (pt),
      .Mispredict      (misp),
      .BranchCount     (bcnt),
      .MispredictCount (mcnt)
   );

   function automatic void chk(input string n, input int k, input logic [31:0] e);
      exp_t x;
      x.name = n;
      x.kind = k;
      x.exp  = e;
      sb.push_back(x);
   endfunction

   function automatic void chk_counts(input string n);
`ifdef BRANCH_PRED_STATS_EN
      chk({n, "_bcnt"}, K_BCNT, bc_m);
      chk({n, "_mcnt"}, K_MCNT, mc_m);
`else
      chk({n, "_bcnt"}, K_BCNT, 32'd0);
      chk({n, "_mcnt"}, K_MCNT, 32'd0);
`endif
   endfunction

   // Advance one edge; count model tracks the inputs that edge samples.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         bc_m = 0;
         mc_m = 0;
      end else if (rv) begin
         bc_m = bc_m + 1;
         if (bt != pt) mc_m = mc_m + 1;
      end
      #1;
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t        e;
         logic [31:0] act;
         e = sb.pop_front();
         case (e.kind)
            K_READY: act = {31'd0, ready};
            K_PRED:  act = {31'd0, pred};
            K_MISP:  act = {31'd0, misp};
            K_BCNT:  act = bcnt;
            default: act = mcnt;
         endcase
         total = total + 1;
         if (act !== e.exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", e.name, act, e.exp, $time);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   // counter walk at index 4: taken outcome and prediction seen before each resolve
   logic seq_bt  [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
   logic seq_pre [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};

   initial begin
      rst = 1; rv = 0; fpc = 0; rpc = 0; bt = 0; pt = 0;
      tick();
      tick();
      // Mispredict is masked while reset is held
      rv = 1; rpc = 32'h0040_0010; bt = 1; pt = 0;
      chk("rst_misp", K_MISP, 0);
      chk("rst_ready", K_READY, 0);
      chk("rst_pred", K_PRED, 0);
      chk_counts("rst");
      tick();
      rst = 0; rv = 0;
      chk_counts("rst_cleared");

      for (int n = 1; n <= 64; n++) begin
         tick();
         fpc = 32'h0040_0000 + 32'(n * 4);
         rv  = 0;
         if (n == 10) begin
            rv = 1; rpc = 32'h0040_0010; bt = 1; pt = 0;
            chk("init_resolve_misp", K_MISP, 1);
         end
         chk($sformatf("init_ready_%0d", n), K_READY, (n == 64) ? 1 : 0);
         chk($sformatf("init_pred_%0d", n), K_PRED, 0);
      end
      rv = 0;
      chk_counts("after_init");

      // every entry must hold 01: one taken flips the MSB
      for (int i = 0; i < 64; i++) begin
         tick();
         fpc = 32'h0040_0000 + 32'(i * 4);
         rv = 1; rpc = fpc; bt = 1; pt = 1;
         chk($sformatf("entry_%0d_init", i), K_PRED, 0);
         chk($sformatf("entry_%0d_misp", i), K_MISP, 0);
         tick();
         rv = 0;
         chk($sformatf("entry_%0d_inc", i), K_PRED, 1);
      end
      chk_counts("after_entries");

      // reset mid-INIT at init index 30
      tick();
      rst = 1;
      tick();
      rst = 0;
      for (int n = 1; n <= 30; n++) begin
         tick();
         chk("mid_ready", K_READY, 0);
      end
      rst = 1;
      tick();
      rst = 0;
      for (int n = 1; n <= 64; n++) begin
         tick();
         chk($sformatf("reinit_ready_%0d", n), K_READY, (n == 64) ? 1 : 0);
      end
      chk_counts("reinit");
      fpc = 32'h0040_0000;
      chk("reinit_e0", K_PRED, 0);
      tick();
      fpc = 32'h0040_007C;
      chk("reinit_e31", K_PRED, 0);
      tick();
      fpc = 32'h0040_00FC;
      chk("reinit_e63", K_PRED, 0);

      // mispredict pair, counts 2/1 afterwards
      tick();
      rv = 1; rpc = 32'h0040_0020; bt = 1; pt = 0;
      chk("misp_t_nt", K_MISP, 1);
      tick();
      bt = 0; pt = 0;
      chk("misp_eq0", K_MISP, 0);
      tick();
      rv = 0;
`ifdef BRANCH_PRED_STATS_EN
      chk("pair_bcnt", K_BCNT, 32'd2);
      chk("pair_mcnt", K_MCNT, 32'd1);
`else
      chk("pair_bcnt", K_BCNT, 32'd0);
      chk("pair_mcnt", K_MCNT, 32'd0);
`endif
      tick();
      rv = 1; bt = 0; pt = 1;
      chk("misp_nt_t", K_MISP, 1);
      tick();
      bt = 1; pt = 1;
      chk("misp_eq1", K_MISP, 0);
      tick();
      rv = 0; bt = 1; pt = 0;
      chk("misp_novalid", K_MISP, 0);

      // consecutive resolves walking the counter at 0x0040_0010
      fpc = 32'h0040_0010;
      rpc = 32'h0040_0010;
      for (int k = 0; k < 9; k++) begin
         tick();
         rv = 1; bt = seq_bt[k]; pt = seq_pre[k];
         chk($sformatf("seq_pred_%0d", k), K_PRED, {31'd0, seq_pre[k]});
         chk($sformatf("seq_misp_%0d", k), K_MISP, {31'd0, seq_bt[k] != seq_pre[k]});
      end
      tick();
      rv = 0;
      chk("seq_final", K_PRED, 1);

      // same-cycle lookup and update, then aliases of the same index
      tick();
      fpc = 32'h0040_0100; rpc = 32'h0040_0100;
      rv = 1; bt = 1; pt = 0;
      chk("same_old", K_PRED, 0);
      chk("same_misp", K_MISP, 1);
      tick();
      rv = 0;
      chk("same_new", K_PRED, 1);
      tick();
      fpc = 32'hABC0_0103;
      chk("alias_hi_lo", K_PRED, 1);
      tick();
      fpc = 32'h0040_0104;
      chk("neighbour", K_PRED, 0);
      chk_counts("final");

      tick();
      tick();
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         bad = bad + 1;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch-direction predictor for the MIPS pipeline. It reads a 2-bit saturating counter for the fetch PC and drives a taken/not-taken prediction into IF. It consumes the resolved outcome from the branch detector, a few stages later, to flag mispredicts and train the table. A post-reset init state machine clears the table one entry per cycle.

## Interface
- INDEX_BITS, 6: log2 of pattern-history-table entries; index = PC[INDEX_BITS+1:2]
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- FetchPC  in  32  PC of instruction currently in IF
- PredictTaken  out  1  MSB of indexed counter; forced 0 while not Ready
- Ready  out  1  table initialised; 0 during INIT
- ResolveValid  in  1  a conditional branch resolves this cycle
- ResolvePC  in  32  PC of resolving branch
- BranchTaken  in  1  actual outcome from branch detector
- PredictedTaken  in  1  prediction carried down the pipeline with that branch
- Mispredict  out  1  ResolveValid & (BranchTaken != PredictedTaken) & ~rst; combinational
- BranchCount  out  32  resolved-branch count (stats feature)
- MispredictCount  out  32  mispredict count (stats feature)

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; taken → +1 saturating at 11, not-taken → −1 saturating at 00.
- States: INIT, READY. rst → INIT, init index 0. INIT: each cycle write 01 to entry[init index], increment; after writing entry 2^INDEX_BITS−1 → READY. READY stays until rst.
- Lookup: combinational, PredictTaken = ~INIT & pht[FetchPC[INDEX_BITS+1:2]][1].
- Update: in READY, on ResolveValid, entry[ResolvePC[INDEX_BITS+1:2]] updated from BranchTaken at the clock edge. Updates during INIT are dropped; Mispredict still reported.
- Same-cycle lookup and update of one index: lookup returns pre-update value.
- Mispredict has no internal state. The pipeline uses it to flush and redirect.
- PC bits [1:0] and bits above INDEX_BITS+1 ignored; aliasing accepted.

## Timing
- Reset values: Ready 0, PredictTaken 0, Mispredict 0, counts 0, state INIT, init index 0.
- INIT: the first edge with rst low writes entry 0, and edge n writes entry n−1. Ready=1 after edge 2^INDEX_BITS (64 for default).
- rst asserted mid-INIT or in READY: next edge restarts INIT at index 0; all table contents are rewritten.
- Lookup latency 0 cycles. Update is visible to lookup 1 cycle after the ResolveValid edge.
- No handshake backpressure: ResolveValid is a single-cycle qualifier. It may be high in consecutive cycles and each cycle is processed.

## Configuration
- BRANCH_PRED_STATS_EN defined: BranchCount +1 on every ResolveValid cycle; MispredictCount +1 when Mispredict=1. Both counters count in INIT and READY, wrap modulo 2^32, and clear on rst.
- Not defined: BranchCount and MispredictCount are tied to 0, no counter flops, and ports are retained.

## Structure
- Shared package: counter encodings (SNT/WNT/WT/ST), INIT/READY state encodings, PHT init value 01.
- One sub-module: sat_counter_update (2-bit current value + taken → next value, combinational).
- PHT is a flop array of 2^INDEX_BITS × 2 bits with one write port and two read indices (lookup and update).

## Test plan
- rst 1 cycle, then idle: Ready=0 for 64 edges, 1 after edge 64. PredictTaken=0 throughout. Every entry reads 01.
- PC 0x0040_0010, resolve taken twice: prediction goes 0 → 1 (after the first update, counter 10) → still 1 (counter 11). Three not-taken resolves: 1,1,0 sequence, ending at counter 00.
- ResolveValid, BranchTaken=1, PredictedTaken=0 → Mispredict=1 same cycle. Equal values → 0. With stats enabled, counts read 2/1 after both cycles.
- Lookup and update of PC 0x0040_0100 in the same cycle: PredictTaken shows old MSB, and the new value appears the next cycle.
- Assert rst at init index 30: init restarts at 0, and Ready rises 64 edges after rst drops.
- Resolve during INIT: table untouched (entry still 01 after Ready), and Mispredict still asserted on mismatch.
